fp_unit_arbiter: RTL

//  Shares one fixed-latency, non-stallable floating-point unit between NUM_REQ requesters.
//  - Round-robin arbiter: issues at most one operand pair per cycle to the unit.
//  - Requester ID and valid travel down a shift pipe matched to the unit latency.
//  - Each result returns tagged with the ID of the requester that issued it.
//  - Sits between the SIMT lanes' FP request ports and the FPMax/FPMin-style units.

---
 rtl/fp_unit_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stallable FP unit between requesters.
// A {valid, id} tag pipe matched to the unit latency returns each result with its requester ID.
module fp_unit_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           unit_a,
  output logic [31:0]           unit_b,
  input  logic [31:0]           unit_q,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic [CNT_W-1:0]      inflight,
  output logic                  idle
);

  logic [ID_W-1:0]                ptr_q, ptr_d;
  logic [LATENCY-1:0]             vld_q, vld_d;
  logic [LATENCY-1:0][ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]               inflight_q, inflight_d;

  logic                           grant_found;
  logic [ID_W-1:0]                grant_idx;
  logic                           handshake;

  // Search order starts at ptr and wraps; the first valid requester along that order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && req_valid[i] && (((32'(ptr_q) + k) % NUM_REQ) == i)) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

  assign handshake = grant_found & en & ~areset;

  always_comb begin
    req_ready = '0;
    unit_a    = '0;
    unit_b    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (handshake && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        unit_a       = req_a[32*i +: 32];
        unit_b       = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = ID_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
    end
  end

  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = handshake;
    id_d[0]  = grant_idx;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      id_d[k]  = id_q[k-1];
    end
  end

  assign resp_valid = vld_q[LATENCY-1];
  assign resp_id    = id_q[LATENCY-1];
  assign resp_data  = unit_q;

  // Issue and retire in the same cycle leave the count unchanged.
  always_comb begin
    inflight_d = inflight_q;
    if (handshake && !resp_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!handshake && resp_valid) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  assign inflight = inflight_q;
  assign idle     = (inflight_q == '0) && (req_valid == '0);

  always_ff @(posedge clk) begin
    if (areset) begin
      ptr_q      <= '0;
      vld_q      <= '0;
      id_q       <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      vld_q      <= vld_d;
      id_q       <= id_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
